// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stall, taken-branch flush, memory-wait stall.
// Optional memory watchdog enabled by defining MEM_TIMEOUT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [4:0]  rs1_Id,
  input  logic [4:0]  rs2_Id,
  input  logic        usesRs1_Id,
  input  logic        usesRs2_Id,
  input  logic        memRead_Ex,
  input  logic [4:0]  rd_Ex,
  input  logic        branchTaken_Ex,
  input  logic        memAccess_Mem,
  input  logic        memReady,
  output logic        memReq,
  output logic        pcEn,
  output logic        ifIdEn,
  output logic        idExEn,
  output logic        exMemEn,
  output logic        memWbEn,
  output logic        ifIdFlush,
  output logic        idExFlush,
  output logic        memWbBubble,
  output logic [15:0] stallCount,
  output logic        memErr
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic {RUN, MEMWAIT} state_t;

  state_t state, state_next;
  logic   load_use;
  logic   force_done;
  logic   mem_stall;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 2..65535");
  end

  assign load_use = memRead_Ex && (rd_Ex != 5'd0) &&
                    ((usesRs1_Id && (rs1_Id == rd_Ex)) || (usesRs2_Id && (rs2_Id == rd_Ex)));

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;

  // A stuck access is released as if memReady had arrived on the last allowed wait cycle.
  assign force_done = (state == MEMWAIT) && memAccess_Mem && !memReady &&
                      (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter sits at zero in RUN so it is already cleared when MEMWAIT is entered.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wait_cnt <= '0;
      memErr   <= 1'b0;
    end else begin
      if (state == RUN) begin
        wait_cnt <= '0;
      end else if (wait_cnt != {CNT_W{1'b1}}) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (force_done) begin
        memErr <= 1'b1;
      end
    end
  end
`else
  assign force_done = 1'b0;
  assign memErr     = 1'b0;
`endif

  assign mem_stall = memAccess_Mem && !memReady && !force_done;

  // State register and saturating stall counter.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= RUN;
      stallCount <= '0;
    end else begin
      state <= state_next;
      if (mem_stall && (stallCount != {CNT_W{1'b1}})) begin
        stallCount <= stallCount + CNT_W'(1);
      end
    end
  end

  // Next state and zero-latency pipeline controls; memStall outranks branch, branch outranks load-use.
  always_comb begin
    state_next  = state;
    memReq      = memAccess_Mem;
    pcEn        = 1'b1;
    ifIdEn      = 1'b1;
    idExEn      = 1'b1;
    exMemEn     = 1'b1;
    memWbEn     = 1'b1;
    ifIdFlush   = 1'b0;
    idExFlush   = 1'b0;
    memWbBubble = 1'b0;

    case (state)
      RUN:     state_next = mem_stall ? MEMWAIT : RUN;
      MEMWAIT: state_next = mem_stall ? MEMWAIT : RUN;
      default: state_next = RUN;
    endcase

    if (!rstN) begin
      memReq  = 1'b0;
      pcEn    = 1'b0;
      ifIdEn  = 1'b0;
      idExEn  = 1'b0;
      exMemEn = 1'b0;
      memWbEn = 1'b0;
    end else if (mem_stall) begin
      pcEn        = 1'b0;
      ifIdEn      = 1'b0;
      idExEn      = 1'b0;
      exMemEn     = 1'b0;
      memWbBubble = 1'b1;
    end else if (branchTaken_Ex) begin
      ifIdFlush = 1'b1;
      idExFlush = 1'b1;
    end else if (load_use) begin
      pcEn      = 1'b0;
      ifIdEn    = 1'b0;
      idExFlush = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; also covers the watchdog when MEM_TIMEOUT_EN is defined.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic [4:0]  rs1_Id, rs2_Id, rd_Ex;
  logic        usesRs1_Id, usesRs2_Id, memRead_Ex, branchTaken_Ex, memAccess_Mem, memReady;
  logic        memReq, pcEn, ifIdEn, idExEn, exMemEn, memWbEn;
  logic        ifIdFlush, idExFlush, memWbBubble, memErr;
  logic [15:0] stallCount;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // {pcEn, ifIdEn, idExEn, exMemEn, memWbEn, ifIdFlush, idExFlush, memWbBubble, memReq}
  localparam logic [8:0] C_RESET   = 9'b00000_000_0;
  localparam logic [8:0] C_NORMAL  = 9'b11111_000_0;
  localparam logic [8:0] C_NORM_MR = 9'b11111_000_1;
  localparam logic [8:0] C_LOADUSE = 9'b00111_010_0;
  localparam logic [8:0] C_BRANCH  = 9'b11111_110_0;
  localparam logic [8:0] C_BR_MR   = 9'b11111_110_1;
  localparam logic [8:0] C_STALL   = 9'b00001_001_1;

  logic [8:0] ctrl;
  assign ctrl = {pcEn, ifIdEn, idExEn, exMemEn, memWbEn, ifIdFlush, idExFlush, memWbBubble, memReq};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rstN(rstN),
    .rs1_Id(rs1_Id), .rs2_Id(rs2_Id), .usesRs1_Id(usesRs1_Id), .usesRs2_Id(usesRs2_Id),
    .memRead_Ex(memRead_Ex), .rd_Ex(rd_Ex), .branchTaken_Ex(branchTaken_Ex),
    .memAccess_Mem(memAccess_Mem), .memReady(memReady), .memReq(memReq),
    .pcEn(pcEn), .ifIdEn(ifIdEn), .idExEn(idExEn), .exMemEn(exMemEn), .memWbEn(memWbEn),
    .ifIdFlush(ifIdFlush), .idExFlush(idExFlush), .memWbBubble(memWbBubble),
    .stallCount(stallCount), .memErr(memErr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
                       input logic mr, input logic [4:0] rd, input logic br,
                       input logic ma, input logic rdy);
    rs1_Id = r1; rs2_Id = r2; usesRs1_Id = u1; usesRs2_Id = u2;
    memRead_Ex = mr; rd_Ex = rd; branchTaken_Ex = br; memAccess_Mem = ma; memReady = rdy;
  endtask

  // Check combinational controls ahead of the next rising edge, then advance to the next drive point.
  task automatic cycle_check(input string tag, input logic [8:0] exp);
    #2;
    check(tag, 32'(ctrl), 32'(exp));
    @(negedge clk);
  endtask

  initial begin
    rstN = 1'b0;
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    #2;
    check("reset_ctrl", 32'(ctrl), 32'(C_RESET));
    check("reset_cnt", 32'(stallCount), 32'd0);
    check("reset_err", 32'(memErr), 32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
    cycle_check("idle", C_NORMAL);

    drive(5'd5, 5'd7, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cycle_check("loaduse_rs1", C_LOADUSE);
    drive(5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle_check("after_loaduse", C_NORMAL);

    drive(5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    cycle_check("loaduse_rs2", C_LOADUSE);
    drive(5'd1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    cycle_check("rs2_unused", C_NORMAL);
    drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle_check("rd_zero", C_NORMAL);

    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    cycle_check("branch_over_lu", C_BRANCH);

    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cycle_check("mem_ready_first", C_NORM_MR);
    check("cnt_no_stall", 32'(stallCount), 32'd0);

    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle_check($sformatf("mem_stall_%0d", i), C_STALL);
    memReady = 1'b1;
    #2;
    check("cnt_after_3", 32'(stallCount), 32'd3);
    cycle_check("mem_done", C_NORM_MR);

    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cycle_check($sformatf("stall_br_%0d", i), C_STALL);
    memReady = 1'b1;
    cycle_check("br_after_ready", C_BR_MR);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle_check("ready_no_access", C_NORMAL);
    check("cnt_after_5", 32'(stallCount), 32'd5);

    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle_check($sformatf("stuck_%0d", i), C_STALL);
`ifdef MEM_TIMEOUT_EN
    cycle_check("forced_release", C_NORM_MR);
`else
    cycle_check("still_waiting", C_STALL);
`endif
    memReady = 1'b1;
    cycle_check("after_stuck", C_NORM_MR);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
`ifdef MEM_TIMEOUT_EN
    check("cnt_stuck", 32'(stallCount), 32'd9);
    check("err_sticky", 32'(memErr), 32'd1);
`else
    check("cnt_stuck", 32'(stallCount), 32'd10);
    check("err_tied", 32'(memErr), 32'd0);
`endif
    @(negedge clk);

    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cycle_check("pre_reset_stall0", C_STALL);
    #2;
    check("pre_reset_stall1", 32'(ctrl), 32'(C_STALL));
    rstN = 1'b0;
    #1;
    check("midwait_rst_ctrl", 32'(ctrl), 32'(C_RESET));
    check("midwait_rst_cnt", 32'(stallCount), 32'd0);
    check("midwait_rst_err", 32'(memErr), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    memAccess_Mem = 1'b0;
    cycle_check("post_reset_idle", C_NORMAL);
    check("post_reset_cnt", 32'(stallCount), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
